// File: rtl/debug_slave_pkg.sv
// ---------------------------------------------------------------------------
// debug_slave_pkg
// Shared definitions for the system-clock half of the Nios II debug slave.
//   - default widths of the JTAG shift register and the virtual IR
//   - default position of the action / no-action selector bit
//   - layout of one queued command entry {ir, data}
//   - channel count derivation and the virtual IR channel encodings
// ---------------------------------------------------------------------------
package debug_slave_pkg;

    localparam int DEF_SR_W    = 38;
    localparam int DEF_IR_W    = 2;
    localparam int DEF_ACT_BIT = 35;

    // Virtual IR channel encodings; each one owns one strobe bit.
    typedef enum logic [DEF_IR_W-1:0] {
        CH_OCIMEM    = 2'd0,
        CH_TRACECTRL = 2'd1,
        CH_BREAK     = 2'd2,
        CH_TRACEMEM  = 2'd3
    } debug_ch_e;

    // One queued command: the IR it was issued under plus the captured data.
    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] data;
    } cmd_entry_t;

    // Every IR value gets its own strobe channel.
    function automatic int numCh(input int irW);
        return 1 << irW;
    endfunction

endpackage

// File: rtl/system_nios2_debug_toggle_sync.sv
// ---------------------------------------------------------------------------
// system_nios2_debug_toggle_sync
// Brings a toggle-encoded event from the TCK domain into clk and turns each
// toggle into a single registered one-cycle pulse.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   tgl_i    in   asynchronous toggle, flips once per event
//   event_o  out  one-cycle pulse, SYNC_STAGES+1 cycles after the toggle
// ---------------------------------------------------------------------------
module system_nios2_debug_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl_i,
    output logic event_o
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       armCnt_q;
    logic                   event_q;
    logic                   synced;
    logic                   armed;

    assign synced = sync_q[SYNC_STAGES-1];
    assign armed  = (armCnt_q == CNT_W'(ARM_CYCLES));

    // Synchroniser chain, edge detector and post-reset arm counter.
    // A toggle that is already high when reset releases ripples through the
    // chain as an apparent edge; the arm counter masks it while prev_q keeps
    // tracking, so by the time events are enabled prev_q already agrees.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            armCnt_q <= '0;
            event_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tgl_i};
            prev_q  <= synced;
            if (!armed) begin
                armCnt_q <= armCnt_q + 1'b1;
            end
            event_q <= armed & (synced ^ prev_q);
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/system_nios2_debug_cmd_sysclk.sv
// ---------------------------------------------------------------------------
// system_nios2_debug_cmd_sysclk
// System-clock side of the Nios II debug slave. Synchronises update-IR and
// update-DR events, queues {ir, sr} commands in a show-ahead FIFO and emits
// one-hot action / no-action strobes together with jdo when a command pops.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   udr_tgl_i, uir_tgl_i  toggle-encoded update-DR / update-IR from TCK
//   ir_in_i, sr_i         quasi-static virtual IR and shift register
//   cmd_ready_i           CPU debug logic accepts the head command
//   clr_ovf_i             clears the sticky overflow flag
//   cmd_valid_o, cmd_ir_o FIFO head status and IR
//   jdo_o                 data of the last popped command
//   take_action_o         one-hot strobe, sr[ACT_BIT]=1
//   take_no_action_o      one-hot strobe, sr[ACT_BIT]=0
//   busy_o                queue non-empty or strobe pending
//   ovf_o                 sticky: a command was dropped
// ---------------------------------------------------------------------------
module system_nios2_debug_cmd_sysclk
    import debug_slave_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int ACT_BIT     = DEF_ACT_BIT,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NUM_CH     = numCh(IR_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              udr_tgl_i,
    input  logic              uir_tgl_i,
    input  logic [IR_W-1:0]   ir_in_i,
    input  logic [SR_W-1:0]   sr_i,
    input  logic              cmd_ready_i,
    input  logic              clr_ovf_i,
    output logic              cmd_valid_o,
    output logic [IR_W-1:0]   cmd_ir_o,
    output logic [SR_W-1:0]   jdo_o,
    output logic [NUM_CH-1:0] take_action_o,
    output logic [NUM_CH-1:0] take_no_action_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic              udrEvt;
    logic              uirEvt;
    logic [IR_W-1:0]   irReg_q;
    logic [IR_W-1:0]   memIr_q   [FIFO_DEPTH];
    logic [SR_W-1:0]   memData_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;
    logic [SR_W-1:0]   jdo_q;
    logic [NUM_CH-1:0] act_q;
    logic [NUM_CH-1:0] act_d;
    logic [NUM_CH-1:0] noAct_q;
    logic [NUM_CH-1:0] noAct_d;
    logic              busy_q;
    logic              ovf_q;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              popNow;
    logic              pushNow;
    logic              dropNow;
    logic [IR_W-1:0]   pushIr;
    logic [IR_W-1:0]   headIr;
    logic [SR_W-1:0]   headData;

    system_nios2_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) udrSync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl_i   (udr_tgl_i),
        .event_o (udrEvt)
    );

    system_nios2_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) uirSync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl_i   (uir_tgl_i),
        .event_o (uirEvt)
    );

    // Queue control and strobe decode. A push into a full queue survives only
    // when the head leaves in the same cycle; otherwise it is dropped and the
    // overflow flag records it. An IR update arriving with a DR update wins,
    // so the command is tagged with the new IR rather than the stale one.
    always_comb begin
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        popNow    = !fifoEmpty && cmd_ready_i;
        pushNow   = udrEvt && (!fifoFull || popNow);
        dropNow   = udrEvt && fifoFull && !popNow;
        pushIr    = uirEvt ? ir_in_i : irReg_q;
        headIr    = memIr_q[rdPtr_q];
        headData  = memData_q[rdPtr_q];

        count_d = count_q;
        if (pushNow && !popNow) begin
            count_d = count_q + 1'b1;
        end else if (popNow && !pushNow) begin
            count_d = count_q - 1'b1;
        end

        act_d   = '0;
        noAct_d = '0;
        if (popNow) begin
            if (headData[ACT_BIT]) begin
                act_d[headIr] = 1'b1;
            end else begin
                noAct_d[headIr] = 1'b1;
            end
        end
    end

    // Queue storage is pure datapath; entries are only read while counted
    // valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pushNow) begin
            memIr_q[wrPtr_q]   <= pushIr;
            memData_q[wrPtr_q] <= sr_i;
        end
    end

    // Control state: IR register, queue pointers, strobes, jdo, busy, overflow.
    // busy is computed from next-state values so it lines up with the queue
    // and strobe registers it summarises.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irReg_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            jdo_q   <= '0;
            act_q   <= '0;
            noAct_q <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (uirEvt) begin
                irReg_q <= ir_in_i;
            end
            if (pushNow) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popNow) begin
                rdPtr_q <= rdPtr_q + 1'b1;
                jdo_q   <= headData;
            end
            count_q <= count_d;
            act_q   <= act_d;
            noAct_q <= noAct_d;
            busy_q  <= (count_d != '0) || popNow;
            if (dropNow) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign cmd_valid_o      = !fifoEmpty;
    assign cmd_ir_o         = fifoEmpty ? '0 : headIr;
    assign jdo_o            = jdo_q;
    assign take_action_o    = act_q;
    assign take_no_action_o = noAct_q;
    assign busy_o           = busy_q;
    assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_system_nios2_debug_cmd_sysclk.sv
// ---------------------------------------------------------------------------
// tb_system_nios2_debug_cmd_sysclk
// Scoreboard bench: stimulus pushes expected commands into a queue, a
// negedge monitor pops them when the DUT pops and checks strobes and jdo.
// ---------------------------------------------------------------------------
module tb_system_nios2_debug_cmd_sysclk;

    localparam int SR_W    = 38;
    localparam int IR_W    = 2;
    localparam int NUM_CH  = 4;
    localparam int ACT_BIT = 35;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              udr_tgl;
    logic              uir_tgl;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              cmd_ready;
    logic              clr_ovf;
    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   jdo;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;
    logic              busy;
    logic              ovf;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
    } expCmd_t;

    int                checks = 0;
    int                errors = 0;
    expCmd_t           expQ[$];
    expCmd_t           pendCmd;
    logic              pendValid = 1'b0;
    logic [IR_W-1:0]   modelIr = '0;
    logic              expOvf = 1'b0;
    logic [SR_W-1:0]   lastJdo = '0;
    logic              udrState = 1'b0;
    logic              uirState = 1'b0;
    logic [NUM_CH-1:0] expTa;
    logic [NUM_CH-1:0] expTna;
    expCmd_t           popped;
    int                lat;

    system_nios2_debug_cmd_sysclk #(
        .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .udr_tgl_i        (udr_tgl),
        .uir_tgl_i        (uir_tgl),
        .ir_in_i          (ir_in),
        .sr_i             (sr),
        .cmd_ready_i      (cmd_ready),
        .clr_ovf_i        (clr_ovf),
        .cmd_valid_o      (cmd_valid),
        .cmd_ir_o         (cmd_ir),
        .jdo_o            (jdo),
        .take_action_o    (take_action),
        .take_no_action_o (take_no_action),
        .busy_o           (busy),
        .ovf_o            (ovf)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck run still reports and terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [SR_W-1:0] randSr(input logic act);
        logic [SR_W-1:0] r;
        r = SR_W'({$urandom(), $urandom()});
        r[ACT_BIT] = act;
        return r;
    endfunction

    // Issue an IR and/or DR update and record the expected command. Optionally
    // raise cmd_ready or clr_ovf for exactly the cycle the DR event reaches the
    // queue (three cycles after the toggle). Holds sr/ir_in stable 8 cycles.
    task automatic applyStimulus(input bit doUir, input bit doUdr,
                                 input logic [IR_W-1:0] irVal, input logic [SR_W-1:0] srVal,
                                 input bit popWith, input bit clrWith, output int latency);
        bit drop;
        expCmd_t e;
        latency = -1;
        ir_in = irVal;
        sr    = srVal;
        if (doUir) begin
            uirState = ~uirState;
            uir_tgl  = uirState;
            modelIr  = irVal;
        end
        if (doUdr) begin
            udrState = ~udrState;
            udr_tgl  = udrState;
            drop = (expQ.size() >= DEPTH) && !popWith;
            if (drop) begin
                expOvf = 1'b1;
            end else begin
                e.ir = modelIr;
                e.sr = srVal;
                expQ.push_back(e);
                if (clrWith) expOvf = 1'b0;
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                if (popWith) cmd_ready = 1'b1;
                if (clrWith) clr_ovf = 1'b1;
            end
            if (c == 4) begin
                if (popWith) cmd_ready = 1'b0;
                if (clrWith) clr_ovf = 1'b0;
            end
            @(negedge clk);
            if (latency < 0 && cmd_valid) latency = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (expQ.size() == 0 && !pendValid) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        if (!done) begin
            errors++;
            $display("[TB] FAIL drainTimeout: actual=%0d left required=0", expQ.size());
        end
        checks++;
        tick(2);
    endtask

    task automatic clearOvf();
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        expOvf  = 1'b0;
        checkOutput("ovfCleared", 64'(ovf), 64'(expOvf));
    endtask

    // Monitor: each negedge compares the strobes and jdo against the command
    // popped on the previous cycle, then records a new pop if one is visible.
    always @(negedge clk) begin
        if (!reset_n) begin
            pendValid = 1'b0;
        end else begin
            expTa  = '0;
            expTna = '0;
            if (pendValid) begin
                if (pendCmd.sr[ACT_BIT]) expTa[pendCmd.ir] = 1'b1;
                else                     expTna[pendCmd.ir] = 1'b1;
                lastJdo = pendCmd.sr;
            end
            checkOutput("take_action", 64'(take_action), 64'(expTa));
            checkOutput("take_no_action", 64'(take_no_action), 64'(expTna));
            checkOutput("jdo", 64'(jdo), 64'(lastJdo));
            pendValid = 1'b0;
            if (cmd_valid && cmd_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPop", 64'(cmd_valid), 64'd0);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("cmd_ir", 64'(cmd_ir), 64'(popped.ir));
                    pendCmd   = popped;
                    pendValid = 1'b1;
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        udr_tgl   = 1'b0;
        uir_tgl   = 1'b0;
        ir_in     = '0;
        sr        = '0;
        cmd_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // Reset state
        checkOutput("rstValid", 64'(cmd_valid), 64'd0);
        checkOutput("rstIr", 64'(cmd_ir), 64'd0);
        checkOutput("rstJdo", 64'(jdo), 64'd0);
        checkOutput("rstTa", 64'(take_action), 64'd0);
        checkOutput("rstTna", 64'(take_no_action), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstOvf", 64'(ovf), 64'd0);
        tick(4);

        // Action command on channel 2, with push-to-valid latency
        cmd_ready = 1'b1;
        applyStimulus(1, 0, 2'd2, '0, 0, 0, lat);
        tick(2);
        applyStimulus(0, 1, 2'd2, 38'h08000000AB, 0, 0, lat);
        checkOutput("validLatency", 64'(lat), 64'd4);
        waitDrain();

        // No-action command on channel 0
        applyStimulus(1, 0, 2'd0, '0, 0, 0, lat);
        applyStimulus(0, 1, 2'd0, randSr(1'b0), 0, 0, lat);
        waitDrain();

        // Random IR/DR traffic with the CPU always ready
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, IR_W'($urandom_range(0, 3)),
                          randSr(1'($urandom_range(0, 1))), 0, 0, lat);
        end
        waitDrain();

        // Overflow: five commands into a four-deep queue
        cmd_ready = 1'b0;
        applyStimulus(1, 0, 2'd1, '0, 0, 0, lat);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 2'd1, randSr(1'($urandom_range(0, 1))), 0, 0, lat);
        end
        checkOutput("ovfSet", 64'(ovf), 64'(expOvf));
        checkOutput("fullValid", 64'(cmd_valid), 64'd1);
        checkOutput("fullBusy", 64'(busy), 64'd1);
        checkOutput("fullIr", 64'(cmd_ir), 64'd1);
        cmd_ready = 1'b1;
        waitDrain();
        cmd_ready = 1'b0;
        checkOutput("drainedValid", 64'(cmd_valid), 64'd0);
        checkOutput("drainedBusy", 64'(busy), 64'd0);
        checkOutput("ovfSticky", 64'(ovf), 64'(expOvf));
        clearOvf();

        // Full queue, push coincides with a pop: nothing dropped
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2'd3, randSr(1'($urandom_range(0, 1))), 0, 0, lat);
        end
        applyStimulus(0, 1, 2'd3, randSr(1'b1), 1, 0, lat);
        checkOutput("pushPopOvf", 64'(ovf), 64'd0);
        checkOutput("pushPopValid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        waitDrain();
        cmd_ready = 1'b0;

        // Overflow and clr_ovf in the same cycle: set wins
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2'd3, randSr(1'($urandom_range(0, 1))), 0, 0, lat);
        end
        applyStimulus(0, 1, 2'd3, randSr(1'b0), 0, 1, lat);
        checkOutput("ovfSetWins", 64'(ovf), 64'(expOvf));
        cmd_ready = 1'b1;
        waitDrain();
        clearOvf();

        // DR without IR update uses the registered IR, not ir_in
        applyStimulus(1, 0, 2'd1, '0, 0, 0, lat);
        applyStimulus(0, 1, 2'd2, randSr(1'b1), 0, 0, lat);
        waitDrain();

        // Reset mid-operation with udr_tgl held high through reset
        cmd_ready = 1'b0;
        applyStimulus(0, 1, 2'd0, randSr(1'b1), 0, 0, lat);
        applyStimulus(0, 1, 2'd0, randSr(1'b0), 0, 0, lat);
        reset_n  = 1'b0;
        udrState = 1'b1;
        udr_tgl  = 1'b1;
        expQ.delete();
        modelIr  = '0;
        expOvf   = 1'b0;
        lastJdo  = '0;
        tick(2);
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        checkOutput("midRstValid", 64'(cmd_valid), 64'd0);
        checkOutput("midRstJdo", 64'(jdo), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("armNoEvent", 64'(cmd_valid), 64'd0);
        end
        tick(1);

        // IR and DR updates together: new IR takes precedence
        applyStimulus(1, 1, 2'd3, randSr(1'b1), 0, 0, lat);
        waitDrain();

        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
